ysyx_041514_icache_axi_rd: RTL and testbench

Read-only bridge between the icache memory port and an AXI4 read channel. It sits directly downstream of the icache miss/uncache engine, alongside the ram_* port group. It converts one held-valid request (address, size, burst length) into a single AXI4 INCR read burst, and returns each beat to the cache as a one-cycle `rdata_ready_o` pulse with 64-bit data. Supported requests are the 8-beat 64-bit line refill and the single-beat 32-bit uncached fetch.

---
 rtl/ysyx_041514_icache_axi_rd.sv | 159 +++++++++++++++
 tb/tb_ysyx_041514_icache_axi_rd.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041514_icache_axi_rd.sv
// Read-only bridge from the icache memory port to an AXI4 read channel.
// One held-valid request becomes a single INCR burst; each beat returns as a one-cycle pulse.
module ysyx_041514_icache_axi_rd #(
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              raddr_valid_i,
  input  logic [7:0]        rmask_i,
  input  logic [3:0]        rsize_i,
  input  logic [7:0]        rlen_i,
  output logic              rdata_ready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic [3:0]        axi_arid_o,
  output logic [ADDR_W-1:0] axi_araddr_o,
  output logic [7:0]        axi_arlen_o,
  output logic [2:0]        axi_arsize_o,
  output logic [1:0]        axi_arburst_o,
  output logic              axi_arvalid_o,
  input  logic              axi_arready_i,
  input  logic [3:0]        axi_rid_i,
  input  logic [DATA_W-1:0] axi_rdata_i,
  input  logic [1:0]        axi_rresp_i,
  input  logic              axi_rlast_i,
  input  logic              axi_rvalid_i,
  output logic              axi_rready_o
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [2:0]          arsize_q, arsize_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rdata_ready_q, rdata_ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [7:0]          beat_cnt_q, beat_cnt_d;
  logic                err_q, err_d;

  // Byte mask only matters for writes; it is accepted and dropped here.
  logic unused_rmask;
  assign unused_rmask = ^rmask_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (raddr_valid_i)                 state_d = S_AR;
      S_AR:   if (axi_arready_i)                 state_d = S_R;
      S_R:    if (axi_rvalid_i && axi_rlast_i)   state_d = S_DONE;
      S_DONE:                                    state_d = S_IDLE;
      default:                                   state_d = S_IDLE;
    endcase
  end

  // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    arsize_d      = arsize_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rdata_ready_d = 1'b0;
    rdata_d       = rdata_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q;
    case (state_q)
      S_IDLE: begin
        if (raddr_valid_i) begin
          araddr_d   = raddr_i;
          arlen_d    = rlen_i;
          arvalid_d  = 1'b1;
          beat_cnt_d = 8'd0;
          case (rsize_i)
            4'd1:    arsize_d = 3'd0;
            4'd2:    arsize_d = 3'd1;
            4'd4:    arsize_d = 3'd2;
            4'd8:    arsize_d = 3'd3;
            default: begin
              arsize_d = 3'd3;
              err_d    = 1'b1;
            end
          endcase
        end
      end
      S_AR: begin
        if (axi_arready_i) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      S_R: begin
        if (axi_rvalid_i) begin
          rdata_d       = axi_rdata_i;
          rdata_ready_d = 1'b1;
          beat_cnt_d    = beat_cnt_q + 8'd1;
          // Protocol violations are flagged but the burst is still drained to rlast.
          if ((axi_rresp_i != 2'b00) || (axi_rid_i != AXI_ID))   err_d = 1'b1;
          if (axi_rlast_i != (beat_cnt_q == arlen_q))            err_d = 1'b1;
          if (axi_rlast_i)                                       rready_d = 1'b0;
        end
      end
      S_DONE: begin
        rready_d = 1'b0;
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      araddr_q      <= '0;
      arlen_q       <= '0;
      arsize_q      <= '0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rdata_ready_q <= 1'b0;
      rdata_q       <= '0;
      beat_cnt_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      arsize_q      <= arsize_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rdata_ready_q <= rdata_ready_d;
      rdata_q       <= rdata_d;
      beat_cnt_q    <= beat_cnt_d;
      err_q         <= err_d;
    end
  end

  assign axi_arid_o    = AXI_ID;
  assign axi_arburst_o = 2'b01;
  assign axi_araddr_o  = araddr_q;
  assign axi_arlen_o   = arlen_q;
  assign axi_arsize_o  = arsize_q;
  assign axi_arvalid_o = arvalid_q;
  assign axi_rready_o  = rready_q;
  assign rdata_ready_o = rdata_ready_q;
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ysyx_041514_icache_axi_rd.sv
// Self-checking bench for the icache AXI read bridge: a scripted AXI slave plus a
// negedge monitor, checked against a request-level model of beats, timing and error flag.
module tb_ysyx_041514_icache_axi_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr_i;
  logic        raddr_valid_i;
  logic [7:0]  rmask_i;
  logic [3:0]  rsize_i;
  logic [7:0]  rlen_i;
  logic        rdata_ready_o;
  logic [63:0] rdata_o;
  logic        err_o;
  logic [3:0]  axi_arid_o;
  logic [31:0] axi_araddr_o;
  logic [7:0]  axi_arlen_o;
  logic [2:0]  axi_arsize_o;
  logic [1:0]  axi_arburst_o;
  logic        axi_arvalid_o;
  logic        axi_arready_i;
  logic [3:0]  axi_rid_i;
  logic [63:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic        axi_rlast_i;
  logic        axi_rvalid_i;
  logic        axi_rready_o;

  ysyx_041514_icache_axi_rd dut (
    .clk(clk), .rst(rst),
    .raddr_i(raddr_i), .raddr_valid_i(raddr_valid_i), .rmask_i(rmask_i),
    .rsize_i(rsize_i), .rlen_i(rlen_i),
    .rdata_ready_o(rdata_ready_o), .rdata_o(rdata_o), .err_o(err_o),
    .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
    .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          exp_err  = 1'b0;
  bit          mon_en   = 1'b0;
  logic [63:0] got_q[$];
  bit          pend     = 1'b0;
  logic [63:0] pend_data;
  bit          prev_arv = 1'b0;
  bit          ar_hold  = 1'b0;
  logic [31:0] sv_addr;
  logic [7:0]  sv_len;
  logic [2:0]  sv_size;
  int          ar_rises = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a beat accepted in cycle b must show up as exactly one pulse in b+1,
  // and the AR fields must not move while arvalid waits for arready.
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if (rdata_ready_o !== pend) begin
        n_fail++;
        $display("FAIL pulse_timing t=%0t got=%b want=%b", $time, rdata_ready_o, pend);
      end
      if (pend && rdata_ready_o === 1'b1) begin
        n_checks++;
        if (rdata_o !== pend_data) begin
          n_fail++;
          $display("FAIL pulse_data t=%0t got=%h want=%h", $time, rdata_o, pend_data);
        end
      end
      if (rdata_ready_o === 1'b1) got_q.push_back(rdata_o);
      if (ar_hold) begin
        n_checks++;
        if (axi_arvalid_o !== 1'b1 || axi_araddr_o !== sv_addr || axi_arlen_o !== sv_len ||
            axi_arsize_o !== sv_size) begin
          n_fail++;
          $display("FAIL ar_stable t=%0t got=%b/%h/%h/%h want=1/%h/%h/%h", $time, axi_arvalid_o,
                   axi_araddr_o, axi_arlen_o, axi_arsize_o, sv_addr, sv_len, sv_size);
        end
      end
      if (axi_arvalid_o === 1'b1 && !prev_arv) ar_rises++;
      prev_arv  = (axi_arvalid_o === 1'b1);
      ar_hold   = (axi_arvalid_o === 1'b1) && !axi_arready_i && !rst;
      sv_addr   = axi_araddr_o;
      sv_len    = axi_arlen_o;
      sv_size   = axi_arsize_o;
      pend      = (axi_rready_o === 1'b1) && axi_rvalid_i && !rst;
      pend_data = axi_rdata_i;
    end
  end

  task automatic check_outputs_zero(input string name);
    n_checks++;
    if (rdata_ready_o !== 1'b0 || rdata_o !== 64'd0 || err_o !== 1'b0 || axi_arvalid_o !== 1'b0 ||
        axi_rready_o !== 1'b0 || axi_araddr_o !== 32'd0 || axi_arlen_o !== 8'd0 ||
        axi_arsize_o !== 3'd0 || axi_arburst_o !== 2'b01 || axi_arid_o !== 4'd0) begin
      n_fail++;
      $display("FAIL %s got rdy=%b data=%h err=%b arv=%b rr=%b addr=%h len=%h size=%h burst=%b id=%h want zeros/burst=01/id=0",
               name, rdata_ready_o, rdata_o, err_o, axi_arvalid_o, axi_rready_o, axi_araddr_o,
               axi_arlen_o, axi_arsize_o, axi_arburst_o, axi_arid_o);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    raddr_valid_i = 1'b0;
    axi_arready_i = 1'b0;
    axi_rvalid_i = 1'b0;
    axi_rlast_i = 1'b0;
    step();
    check_outputs_zero("reset_state");
    rst = 1'b0;
    exp_err = 1'b0;
    step();
  endtask

  // One complete request from the cache's point of view. last_at is the index of the
  // beat carrying rlast; abort_at >= 0 hits rst right after that beat.
  task automatic do_request(input logic [31:0] addr, input int size, input int len,
                            input int ar_delay, input int gap, input int last_at,
                            input int bad_resp_at, input int bad_id_at, input int abort_at,
                            input bit seq_data, input bit early_drop);
    logic [63:0] exp_q[$];
    logic [63:0] d;
    logic [2:0]  e_size;
    bit          bad_size;
    got_q.delete();
    bad_size = !(size inside {1, 2, 4, 8});
    e_size   = bad_size ? 3'd3 : 3'($clog2(size));
    raddr_i = addr; rsize_i = 4'(size); rlen_i = 8'(len); rmask_i = 8'hff;
    raddr_valid_i = 1'b1; axi_arready_i = 1'b0;
    step();
    n_checks++;
    if (axi_arvalid_o !== 1'b1 || axi_araddr_o !== addr || axi_arlen_o !== 8'(len) ||
        axi_arsize_o !== e_size || axi_arburst_o !== 2'b01 || axi_arid_o !== 4'd0) begin
      n_fail++;
      $display("FAIL ar_issue got arv=%b addr=%h len=%h size=%h burst=%b id=%h want 1/%h/%h/%h/01/0",
               axi_arvalid_o, axi_araddr_o, axi_arlen_o, axi_arsize_o, axi_arburst_o, axi_arid_o,
               addr, 8'(len), e_size);
    end
    repeat (ar_delay) step();
    axi_arready_i = 1'b1;
    step();
    axi_arready_i = 1'b0;
    if (early_drop) raddr_valid_i = 1'b0;
    n_checks++;
    if (axi_arvalid_o !== 1'b0 || axi_rready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ar_done got arv=%b rready=%b want 0/1", axi_arvalid_o, axi_rready_o);
    end
    for (int i = 0; i <= last_at; i++) begin
      repeat (gap) step();
      d = seq_data ? 64'(i) : {$urandom, $urandom};
      exp_q.push_back(d);
      axi_rvalid_i = 1'b1;
      axi_rdata_i  = d;
      axi_rlast_i  = (i == last_at);
      axi_rresp_i  = (i == bad_resp_at) ? 2'b10 : 2'b00;
      axi_rid_i    = (i == bad_id_at) ? 4'd5 : 4'd0;
      step();
      axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0; axi_rresp_i = 2'b00; axi_rid_i = 4'd0;
      if (i == abort_at) begin
        rst = 1'b1;
        raddr_valid_i = 1'b0;
        step();
        check_outputs_zero("reset_mid_burst");
        rst = 1'b0;
        exp_err = 1'b0;
        step();
        return;
      end
    end
    raddr_valid_i = 1'b0;
    step();
    step();
    n_checks++;
    if (axi_arvalid_o !== 1'b0 || axi_rready_o !== 1'b0 || rdata_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_last got arv=%b rready=%b rdy=%b want 0/0/0",
               axi_arvalid_o, axi_rready_o, rdata_ready_o);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL pulse_count got=%0d want=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL beat_order idx=%0d got=%h want=%h", k, got_q[k], exp_q[k]);
        end
      end
    end
    if (bad_size || (bad_resp_at >= 0 && bad_resp_at <= last_at) ||
        (bad_id_at >= 0 && bad_id_at <= last_at) || last_at != len)
      exp_err = 1'b1;
    n_checks++;
    if (err_o !== exp_err) begin
      n_fail++;
      $display("FAIL err_flag got=%b want=%b", err_o, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    check_outputs_zero("reset_state");
    rst = 1'b0;
    mon_en = 1'b1;
    step();
  endtask

  task automatic test_line_refill();
    do_request(32'h8000_0040, 8, 7, 0, 0, 7, -1, -1, -1, 1'b1, 1'b0);
  endtask

  task automatic test_uncached();
    do_request(32'hA000_0004, 4, 0, 0, 0, 0, -1, -1, -1, 1'b0, 1'b0);
    do_request({$urandom} & 32'hFFFF_FFC0, 8, 7, $urandom_range(0, 3), $urandom_range(0, 2),
               7, -1, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_request(32'h8000_1000, 8, 7, 5, 2, 7, -1, -1, -1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = ar_rises;
    do_request(32'h8000_2000, 8, 7, 0, 0, 7, -1, -1, -1, 1'b0, 1'b0);
    do_request(32'h8000_2040, 8, 7, 1, 0, 7, -1, -1, -1, 1'b0, 1'b0);
    repeat (3) step();
    n_checks++;
    if (ar_rises - r0 != 2) begin
      n_fail++;
      $display("FAIL ar_count got=%0d want=2", ar_rises - r0);
    end
  endtask

  task automatic test_errors();
    apply_reset();
    do_request(32'h8000_3000, 8, 7, 0, 0, 7, 3, -1, -1, 1'b0, 1'b0);
    do_request(32'h8000_3040, 8, 7, 0, 0, 7, -1, -1, -1, 1'b0, 1'b0);
    apply_reset();
    do_request(32'h8000_3080, 8, 7, 0, 1, 5, -1, -1, -1, 1'b0, 1'b0);
    apply_reset();
    do_request(32'h8000_30C0, 8, 7, 0, 0, 8, -1, -1, -1, 1'b0, 1'b0);
    apply_reset();
    do_request(32'h8000_3100, 8, 7, 0, 0, 7, -1, 6, -1, 1'b0, 1'b0);
    apply_reset();
    do_request(32'hA000_0010, 3, 0, 0, 0, 0, -1, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    do_request(32'h8000_4000, 8, 7, 0, 0, 7, 0, -1, 2, 1'b0, 1'b0);
    do_request(32'h8000_0040, 8, 7, 0, 0, 7, -1, -1, -1, 1'b1, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    raddr_i = '0; raddr_valid_i = 1'b0; rmask_i = '0; rsize_i = '0; rlen_i = '0;
    axi_arready_i = 1'b0; axi_rid_i = '0; axi_rdata_i = '0; axi_rresp_i = '0;
    axi_rlast_i = 1'b0; axi_rvalid_i = 1'b0;
    test_reset();
    test_line_refill();
    test_uncached();
    test_backpressure();
    test_back_to_back();
    test_errors();
    test_reset_mid_burst();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
